// File: rtl/lrpt_pkg.sv
// Shared LRPT constants and types: CADU sync marker, frame size, CCSDS PN polynomial
// and the framer state encoding.
package lrpt_pkg;

    localparam logic [31:0] CADU_SYNC_WORD      = 32'h1ACFFC1D;
    localparam int          CADU_BITS_PER_FRAME = 32'd8192;
    localparam logic [7:0]  PN_SEED             = 8'hFF;
    // h(x) = x^8+x^7+x^5+x^3+1 with the oldest bit in [7]: feedback from bits 7,4,2,0
    localparam logic [7:0]  PN_TAPS             = 8'h95;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SYNC    = 2'd1,
        PAYLOAD = 2'd2
    } cadu_framer_state;

    function automatic logic pn_feedback(input logic [7:0] state);
        return ^(state & PN_TAPS);
    endfunction

endpackage

// File: rtl/ccsds_pn_gen.sv
// CCSDS pseudo-random sequence generator (Fibonacci LFSR, output = MSB); shared by
// the transmit framer and the receive-side derandomizer.
module ccsds_pn_gen
    import lrpt_pkg::*;
(
    input  logic clk,
    input  logic rst_in,
    input  logic init,
    input  logic adv,
    output logic pn_bit
);

    logic [7:0] sr_r;

    // LFSR state: reseed on init, step once per consumed PN bit
    always_ff @(posedge clk) begin
        if (rst_in) begin
            sr_r <= PN_SEED;
        end else if (init) begin
            sr_r <= PN_SEED;
        end else if (adv) begin
            sr_r <= {sr_r[6:0], pn_feedback(sr_r)};
        end
    end

    assign pn_bit = sr_r[7];

endmodule

// File: rtl/cadu_framer.sv
// CADU framer: prefixes each CVCDU payload with the attached sync marker and
// serialises the frame MSB first, optionally randomised with the CCSDS PN sequence.
module cadu_framer
    import lrpt_pkg::*;
#(
    parameter int          BITS_PER_FRAME = CADU_BITS_PER_FRAME,
    parameter logic [31:0] SYNC_WORD      = CADU_SYNC_WORD,
    parameter bit          RANDOMIZE      = 1'b1
) (
    input  logic        clk,
    input  logic        rst_in,
    input  logic [7:0]  data_in,
    input  logic        valid_in,
    output logic        ready_out,
    output logic        bit_out,
    output logic        valid_out,
    input  logic        ready_in,
    output logic        frame_start,
    output logic        frame_done,
    output logic        underrun,
    output logic [15:0] frames_sent
);

    localparam int            CW         = $clog2(BITS_PER_FRAME);
    localparam logic [CW-1:0] FRAME_LAST = CW'(BITS_PER_FRAME - 32'sd1);
    localparam logic [CW-1:0] SYNC_LAST  = CW'(32'd31);
    localparam logic [CW-1:0] CNT_ONE    = CW'(32'd1);

    cadu_framer_state state_r;
    logic [CW-1:0]    bit_cnt_r;
    logic [7:0]       shift_r;
    logic [7:0]       hold_r;
    logic             hold_valid_r;
    logic             bit_out_r;
    logic             valid_out_r;
    logic             frame_start_r;
    logic             frame_done_r;
    logic             underrun_r;
    logic [15:0]      frames_sent_r;

    logic accept_s;
    logic byte_take_s;
    logic last_sync_s;
    logic frame_end_s;
    logic byte_edge_s;
    logic load_byte_s;
    logic underrun_s;
    logic mid_byte_s;
    logic pn_adv_s;
    logic pn_init_s;
    logic pn_bit_s;
    logic payload_bit_s;

    // bit_cnt_r is the index of the bit on bit_out, or of the next bit while starved
    assign accept_s    = valid_out_r && ready_in;
    assign byte_take_s = valid_in && !hold_valid_r;
    assign last_sync_s = (state_r == SYNC) && accept_s && (bit_cnt_r == SYNC_LAST);
    assign frame_end_s = (state_r == PAYLOAD) && accept_s && (bit_cnt_r == FRAME_LAST);
    assign byte_edge_s = (state_r == PAYLOAD) && !frame_end_s &&
                         ((accept_s && (bit_cnt_r[2:0] == 3'd7)) || !valid_out_r);
    assign load_byte_s = (last_sync_s || byte_edge_s) && hold_valid_r;
    assign underrun_s  = byte_edge_s && valid_out_r && !hold_valid_r;
    assign mid_byte_s  = (state_r == PAYLOAD) && accept_s && (bit_cnt_r[2:0] != 3'd7);
    assign pn_adv_s    = load_byte_s || mid_byte_s;
    // PN sits at the seed outside the payload so the first payload bit uses it directly
    assign pn_init_s   = (state_r != PAYLOAD) && !pn_adv_s;

    assign payload_bit_s = (load_byte_s ? hold_r[7] : shift_r[7]) ^ (RANDOMIZE && pn_bit_s);

    ccsds_pn_gen u_pn (
        .clk    (clk),
        .rst_in (rst_in),
        .init   (pn_init_s),
        .adv    (pn_adv_s),
        .pn_bit (pn_bit_s)
    );

    // Upstream holding register: filled on a byte handshake, emptied when the shifter loads
    always_ff @(posedge clk) begin
        if (rst_in) begin
            hold_valid_r <= 1'b0;
            hold_r       <= 8'h00;
        end else if (byte_take_s) begin
            hold_valid_r <= 1'b1;
            hold_r       <= data_in;
        end else if (load_byte_s) begin
            hold_valid_r <= 1'b0;
        end
    end

    // Framing FSM with registered serial output and status pulses
    always_ff @(posedge clk) begin
        if (rst_in) begin
            state_r       <= IDLE;
            bit_cnt_r     <= '0;
            shift_r       <= 8'h00;
            bit_out_r     <= 1'b0;
            valid_out_r   <= 1'b0;
            frame_start_r <= 1'b0;
            frame_done_r  <= 1'b0;
            underrun_r    <= 1'b0;
            frames_sent_r <= 16'h0000;
        end else begin
            frame_start_r <= 1'b0;
            frame_done_r  <= 1'b0;
            underrun_r    <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (hold_valid_r) begin
                        state_r       <= SYNC;
                        bit_cnt_r     <= '0;
                        bit_out_r     <= SYNC_WORD[31];
                        valid_out_r   <= 1'b1;
                        frame_start_r <= 1'b1;
                    end
                end
                SYNC: begin
                    if (last_sync_s) begin
                        state_r   <= PAYLOAD;
                        bit_cnt_r <= bit_cnt_r + CNT_ONE;
                        bit_out_r <= payload_bit_s;
                        shift_r   <= {hold_r[6:0], 1'b0};
                    end else if (accept_s) begin
                        bit_cnt_r <= bit_cnt_r + CNT_ONE;
                        bit_out_r <= SYNC_WORD[5'd30 - bit_cnt_r[4:0]];
                    end
                end
                PAYLOAD: begin
                    if (frame_end_s) begin
                        frame_done_r  <= 1'b1;
                        frames_sent_r <= frames_sent_r + 16'd1;
                        bit_cnt_r     <= '0;
                        if (hold_valid_r) begin
                            state_r       <= SYNC;
                            bit_out_r     <= SYNC_WORD[31];
                            frame_start_r <= 1'b1;
                        end else begin
                            state_r     <= IDLE;
                            bit_out_r   <= 1'b0;
                            valid_out_r <= 1'b0;
                        end
                    end else if (load_byte_s) begin
                        bit_out_r   <= payload_bit_s;
                        valid_out_r <= 1'b1;
                        shift_r     <= {hold_r[6:0], 1'b0};
                        if (valid_out_r) begin
                            bit_cnt_r <= bit_cnt_r + CNT_ONE;
                        end
                    end else if (underrun_s) begin
                        valid_out_r <= 1'b0;
                        underrun_r  <= 1'b1;
                        bit_cnt_r   <= bit_cnt_r + CNT_ONE;
                    end else if (mid_byte_s) begin
                        bit_out_r <= payload_bit_s;
                        shift_r   <= {shift_r[6:0], 1'b0};
                        bit_cnt_r <= bit_cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    valid_out_r <= 1'b0;
                end
            endcase
        end
    end

    assign ready_out   = !hold_valid_r;
    assign bit_out     = bit_out_r;
    assign valid_out   = valid_out_r;
    assign frame_start = frame_start_r;
    assign frame_done  = frame_done_r;
    assign underrun    = underrun_r;
    assign frames_sent = frames_sent_r;

endmodule

// File: tb/tb_cadu_framer.sv
// Bench for cadu_framer: a randomised and a plain instance share one stimulus stream;
// both serial outputs are compared against a frame/PN model built from the framing rules.
module tb_cadu_framer;

    localparam int          FRAME_BITS    = 8192;
    localparam int          PAYLOAD_BYTES = 1020;
    localparam logic [31:0] ASM           = 32'h1ACFFC1D;

    logic        clk      = 1'b0;
    logic        rst_in   = 1'b1;
    logic [7:0]  data_in  = 8'h00;
    logic        valid_in = 1'b0;
    logic        ready_in = 1'b1;

    logic        ready_out_a, bit_out_a, valid_out_a, frame_start_a, frame_done_a, underrun_a;
    logic [15:0] frames_sent_a;
    logic        ready_out_b, bit_out_b, valid_out_b, frame_start_b, frame_done_b, underrun_b;
    logic [15:0] frames_sent_b;

    always #5 clk = ~clk;

    cadu_framer #(.RANDOMIZE(1'b1)) dut_a (
        .clk(clk), .rst_in(rst_in), .data_in(data_in), .valid_in(valid_in),
        .ready_out(ready_out_a), .bit_out(bit_out_a), .valid_out(valid_out_a),
        .ready_in(ready_in), .frame_start(frame_start_a), .frame_done(frame_done_a),
        .underrun(underrun_a), .frames_sent(frames_sent_a)
    );

    cadu_framer #(.RANDOMIZE(1'b0)) dut_b (
        .clk(clk), .rst_in(rst_in), .data_in(data_in), .valid_in(valid_in),
        .ready_out(ready_out_b), .bit_out(bit_out_b), .valid_out(valid_out_b),
        .ready_in(ready_in), .frame_start(frame_start_b), .frame_done(frame_done_b),
        .underrun(underrun_b), .frames_sent(frames_sent_b)
    );

    int         total = 0;
    int         bad   = 0;
    bit         pn [FRAME_BITS-32];
    logic [7:0] byte_q[$];
    bit         cap_a[$];
    bit         cap_b[$];
    int         start_pos[$];
    int         n_start, n_done, n_under, stall_viol, pair_diff, idle_cycles, latency;
    bit         timed_out;

    // Expected serial bit idx of the stream: marker, then payload bytes MSB first (^ PN)
    function automatic bit exp_bit(input int idx, input bit rnd);
        logic [31:0] asm_w;
        logic [7:0]  b;
        int          off;
        int          p;
        asm_w = ASM;
        off = idx % FRAME_BITS;
        if (off < 32) return asm_w[31 - off];
        p = off - 32;
        b = byte_q[(idx / FRAME_BITS) * PAYLOAD_BYTES + p / 8];
        return b[7 - p % 8] ^ (rnd & pn[p]);
    endfunction

    function automatic int stream_errors(input bit use_a, input int nbits);
        int errs = 0;
        int n;
        n = use_a ? cap_a.size() : cap_b.size();
        if (n != nbits) errs = errs + ((n > nbits) ? n - nbits : nbits - n);
        for (int i = 0; i < nbits && i < n; i++) begin
            if ((use_a ? cap_a[i] : cap_b[i]) != exp_bit(i, use_a)) errs++;
        end
        return errs;
    endfunction

    task automatic do_reset();
        rst_in   = 1'b1;
        valid_in = 1'b0;
        ready_in = 1'b1;
        repeat (2) @(negedge clk);
        rst_in = 1'b0;
    endtask

    task automatic fill_random(input int nbytes);
        byte_q.delete();
        for (int i = 0; i < nbytes; i++) byte_q.push_back(8'($urandom_range(0, 255)));
    endtask

    // Drives byte_q upstream and captures handshaken bits; all sampling on negedge
    task automatic run_stream(input int nframes, input bit stall, input int hold_idx,
                              input int hold_len, input int stop_after);
        int byte_idx = 0;
        int held = 0;
        int cyc = 0;
        int accept_cyc = -1;
        int start_cyc = -1;
        int target;
        int budget;
        bit seen_valid = 1'b0;
        bit prev_stall = 1'b0;
        bit prev_a = 1'b0;
        bit prev_b = 1'b0;
        target = (stop_after > 0) ? stop_after : nframes * FRAME_BITS;
        budget = nframes * FRAME_BITS * 3 + 500;
        cap_a.delete(); cap_b.delete(); start_pos.delete();
        n_start = 0; n_done = 0; n_under = 0; stall_viol = 0; pair_diff = 0; idle_cycles = 0;
        while (cap_a.size() < target && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (prev_stall && (bit_out_a !== prev_a || bit_out_b !== prev_b ||
                               valid_out_a !== 1'b1 || valid_out_b !== 1'b1)) stall_viol++;
            if ({ready_out_b, valid_out_b, frame_start_b, frame_done_b, underrun_b, frames_sent_b} !==
                {ready_out_a, valid_out_a, frame_start_a, frame_done_a, underrun_a, frames_sent_a})
                pair_diff++;
            if (frame_start_a) begin
                start_pos.push_back(cap_a.size());
                if (start_cyc < 0) start_cyc = cyc;
            end
            n_start += int'(frame_start_a);
            n_done  += int'(frame_done_a);
            n_under += int'(underrun_a);
            if (valid_out_a) seen_valid = 1'b1;
            else if (seen_valid) idle_cycles++;
            ready_in = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (byte_idx == hold_idx && held < hold_len) begin
                valid_in = 1'b0;
                if (ready_out_a) held++;
            end else begin
                valid_in = (byte_idx < byte_q.size());
                data_in  = valid_in ? byte_q[byte_idx] : 8'h00;
            end
            if (valid_in && ready_out_a) begin
                if (accept_cyc < 0) accept_cyc = cyc;
                byte_idx++;
            end
            if (valid_out_a && ready_in) begin
                cap_a.push_back(bit_out_a);
                cap_b.push_back(bit_out_b);
            end
            prev_stall = valid_out_a && !ready_in;
            prev_a = bit_out_a;
            prev_b = bit_out_b;
        end
        timed_out = (cap_a.size() < target);
        latency = start_cyc - accept_cyc;
        if (stop_after == 0) begin
            repeat (3) begin
                @(negedge clk);
                n_start += int'(frame_start_a);
                n_done  += int'(frame_done_a);
                n_under += int'(underrun_a);
                ready_in = 1'b1;
                valid_in = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        rst_in = 1'b1; valid_in = 1'b0; ready_in = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({valid_out_a, bit_out_a, ready_out_a, frame_start_a, frame_done_a, underrun_a, frames_sent_a}
            !== {6'b001000, 16'h0000}) begin
            bad++;
            $display("FAIL reset_a: got v=%b b=%b r=%b fs=%b fd=%b u=%b n=%0d, want 0 0 1 0 0 0 0",
                     valid_out_a, bit_out_a, ready_out_a, frame_start_a, frame_done_a, underrun_a, frames_sent_a);
        end
        total++;
        if ({valid_out_b, bit_out_b, ready_out_b, frame_start_b, frame_done_b, underrun_b, frames_sent_b}
            !== {6'b001000, 16'h0000}) begin
            bad++;
            $display("FAIL reset_b: got v=%b r=%b n=%0d, want v=0 r=1 n=0", valid_out_b, ready_out_b, frames_sent_b);
        end
        rst_in = 1'b0;
    endtask

    task automatic test_zero_frame();
        logic [31:0] asm_got = 32'h0;
        logic [31:0] pn_got  = 32'h0;
        int e;
        do_reset();
        byte_q.delete();
        repeat (PAYLOAD_BYTES) byte_q.push_back(8'h00);
        run_stream(1, 1'b0, -1, 0, 0);
        total++; if (timed_out !== 1'b0) begin bad++; $display("FAIL zero_timeout: got %0d bits, want %0d", cap_a.size(), FRAME_BITS); end
        for (int i = 0; i < 32; i++) begin
            if (i < cap_a.size()) asm_got = {asm_got[30:0], cap_a[i]};
            if (i + 32 < cap_a.size()) pn_got = {pn_got[30:0], cap_a[i + 32]};
        end
        total++; if (asm_got !== 32'h1ACFFC1D) begin bad++; $display("FAIL zero_asm: got %h want 1acffc1d", asm_got); end
        total++; if (pn_got !== 32'hFF480EC0) begin bad++; $display("FAIL zero_pn: got %h want ff480ec0", pn_got); end
        e = stream_errors(1'b1, FRAME_BITS);
        total++; if (e !== 0) begin bad++; $display("FAIL zero_stream_rnd: %0d bit errors, want 0", e); end
        e = stream_errors(1'b0, FRAME_BITS);
        total++; if (e !== 0) begin bad++; $display("FAIL zero_stream_raw: %0d bit errors, want 0", e); end
        total++; if (n_start !== 1 || n_done !== 1) begin bad++; $display("FAIL zero_pulses: start=%0d done=%0d, want 1 1", n_start, n_done); end
        total++; if (frames_sent_a !== 16'd1) begin bad++; $display("FAIL zero_count: got %0d want 1", frames_sent_a); end
        total++; if (latency !== 2) begin bad++; $display("FAIL zero_latency: got %0d want 2", latency); end
        total++; if (idle_cycles !== 0 || pair_diff !== 0) begin bad++; $display("FAIL zero_gapless: idle=%0d pairdiff=%0d, want 0 0", idle_cycles, pair_diff); end
    endtask

    task automatic test_incrementing();
        int e;
        do_reset();
        byte_q.delete();
        for (int i = 0; i < PAYLOAD_BYTES; i++) byte_q.push_back(8'(i % 256));
        run_stream(1, 1'b0, -1, 0, 0);
        total++; if (timed_out !== 1'b0) begin bad++; $display("FAIL inc_timeout: got %0d bits", cap_b.size()); end
        e = stream_errors(1'b0, FRAME_BITS);
        total++; if (e !== 0) begin bad++; $display("FAIL inc_stream_raw: %0d bit errors, want 0", e); end
        e = stream_errors(1'b1, FRAME_BITS);
        total++; if (e !== 0) begin bad++; $display("FAIL inc_stream_rnd: %0d bit errors, want 0", e); end
        total++; if (frames_sent_b !== 16'd1 || n_under !== 0) begin bad++; $display("FAIL inc_count: frames=%0d underruns=%0d, want 1 0", frames_sent_b, n_under); end
    endtask

    task automatic test_stall();
        int e;
        do_reset();
        fill_random(PAYLOAD_BYTES);
        run_stream(1, 1'b1, -1, 0, 0);
        total++; if (timed_out !== 1'b0) begin bad++; $display("FAIL stall_timeout: got %0d bits", cap_a.size()); end
        total++; if (stall_viol !== 0) begin bad++; $display("FAIL stall_stable: %0d unstable cycles, want 0", stall_viol); end
        e = stream_errors(1'b1, FRAME_BITS) + stream_errors(1'b0, FRAME_BITS);
        total++; if (e !== 0) begin bad++; $display("FAIL stall_stream: %0d bit errors, want 0", e); end
        total++; if (n_start !== 1 || n_done !== 1 || n_under !== 0) begin bad++; $display("FAIL stall_pulses: start=%0d done=%0d under=%0d, want 1 1 0", n_start, n_done, n_under); end
    endtask

    task automatic test_underrun();
        int e;
        do_reset();
        fill_random(PAYLOAD_BYTES);
        run_stream(1, 1'b0, 10, 20, 0);
        total++; if (timed_out !== 1'b0) begin bad++; $display("FAIL under_timeout: got %0d bits", cap_a.size()); end
        total++; if (n_under !== 1) begin bad++; $display("FAIL under_pulses: got %0d want 1", n_under); end
        total++; if (idle_cycles < 1 || idle_cycles > 20) begin bad++; $display("FAIL under_gap: idle=%0d, want 1..20", idle_cycles); end
        e = stream_errors(1'b1, FRAME_BITS) + stream_errors(1'b0, FRAME_BITS);
        total++; if (e !== 0) begin bad++; $display("FAIL under_stream: %0d bit errors, want 0", e); end
    endtask

    task automatic test_back_to_back();
        int e;
        do_reset();
        fill_random(3 * PAYLOAD_BYTES);
        run_stream(3, 1'b0, -1, 0, 0);
        total++; if (timed_out !== 1'b0) begin bad++; $display("FAIL b2b_timeout: got %0d bits", cap_a.size()); end
        total++;
        if (start_pos.size() !== 3 || start_pos[0] !== 0 || start_pos[1] !== FRAME_BITS || start_pos[2] !== 2 * FRAME_BITS) begin
            bad++;
            $display("FAIL b2b_sync_pos: %0d starts, first offsets %0d %0d, want 0 8192 16384", start_pos.size(),
                     (start_pos.size() > 0) ? start_pos[0] : -1, (start_pos.size() > 1) ? start_pos[1] : -1);
        end
        total++; if (idle_cycles !== 0) begin bad++; $display("FAIL b2b_idle: got %0d idle cycles, want 0", idle_cycles); end
        total++; if (frames_sent_a !== 16'd3 || n_done !== 3) begin bad++; $display("FAIL b2b_count: frames=%0d done=%0d, want 3 3", frames_sent_a, n_done); end
        e = stream_errors(1'b1, 3 * FRAME_BITS) + stream_errors(1'b0, 3 * FRAME_BITS);
        total++; if (e !== 0) begin bad++; $display("FAIL b2b_stream: %0d bit errors, want 0", e); end
    endtask

    task automatic test_reset_mid();
        int e;
        do_reset();
        fill_random(PAYLOAD_BYTES);
        run_stream(1, 1'b0, -1, 0, 500);
        rst_in = 1'b1;
        valid_in = 1'b0;
        @(negedge clk);
        total++;
        if ({valid_out_a, bit_out_a, ready_out_a, frame_start_a, frame_done_a, underrun_a, frames_sent_a,
             valid_out_b, bit_out_b, ready_out_b} !== {6'b001000, 16'h0000, 3'b001}) begin
            bad++;
            $display("FAIL midrst_outputs: va=%b ba=%b ra=%b vb=%b rb=%b, want 0 0 1 0 1",
                     valid_out_a, bit_out_a, ready_out_a, valid_out_b, ready_out_b);
        end
        rst_in = 1'b0;
        fill_random(PAYLOAD_BYTES);
        run_stream(1, 1'b0, -1, 0, 0);
        e = stream_errors(1'b1, FRAME_BITS) + stream_errors(1'b0, FRAME_BITS);
        total++; if (e !== 0 || timed_out !== 1'b0) begin bad++; $display("FAIL midrst_stream: %0d bit errors timeout=%b, want 0 0", e, timed_out); end
        total++; if (n_start !== 1 || frames_sent_a !== 16'd1) begin bad++; $display("FAIL midrst_count: start=%0d frames=%0d, want 1 1", n_start, frames_sent_a); end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) pn[i] = 1'b1;
        for (int i = 8; i < FRAME_BITS - 32; i++) pn[i] = pn[i-1] ^ pn[i-3] ^ pn[i-5] ^ pn[i-8];
        test_reset();
        test_zero_frame();
        test_incrementing();
        test_stall();
        test_underrun();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cadu_framer.md
# cadu_framer

Transmit-side CADU framer for the LRPT chain. It accepts the CVCDU payload as a byte stream and emits a serial bit stream of CADU frames. Each frame is the 32-bit attached sync marker 0x1ACFFC1D followed by the payload. The payload is optionally XORed with the CCSDS pseudo-random sequence. The block generates loopback and test streams for the CADU sync correlator, so its output framing must match exactly what that correlator searches for.

## Interface
Parameters:
- BITS_PER_FRAME, 1024*8: total CADU bits per frame, sync marker included; payload is BITS_PER_FRAME-32 bits (1020 bytes).
- SYNC_WORD, 32'h1ACFFC1D: attached sync marker, sent MSB first.
- RANDOMIZE, 1: 1 = XOR payload with the CCSDS PN sequence; 0 = payload passes through unchanged.

Ports:
- clk  input  1  single system clock.
- rst_in  input  1  reset; synchronous, active-high.
- data_in  input  8  payload byte, sent MSB first.
- valid_in  input  1  data_in is valid.
- ready_out  output  1  block can accept a byte; equals !hold_valid.
- bit_out  output  1  serial CADU bit.
- valid_out  output  1  bit_out is valid.
- ready_in  input  1  downstream accepts bit_out.
- frame_start  output  1  one-cycle pulse in the cycle the first sync-marker bit first appears on bit_out.
- frame_done  output  1  one-cycle pulse on the cycle after the last payload bit handshakes.
- underrun  output  1  one-cycle pulse when the payload stalls because no byte is available.
- frames_sent  output  16  count of completed frames; wraps.

## Operation
- One-byte holding register (hold_reg, hold_valid).
  - A byte is accepted when valid_in && ready_out.
  - hold_valid clears when the byte moves into the 8-bit shift register.
- Advance condition: adv = !valid_out || ready_in. Outputs change only on adv cycles.
- States:
  - IDLE: valid_out=0. If hold_valid, go to SYNC and present SYNC_WORD[31] with valid_out=1 and frame_start=1.
  - SYNC: on each adv, present the next marker bit, 31 down to 0. After bit 0 is accepted, load the shift register from hold_reg, seed the PN generator with 0xFF, and go to PAYLOAD.
  - PAYLOAD:
    - Each adv presents shift_reg[7] ^ (RANDOMIZE ? pn_bit : 0), then shifts and advances the PN generator.
    - At a byte boundary, reload the shift register from hold_reg.
    - If hold_valid=0 at the boundary: valid_out=0, pulse underrun once, and hold the payload bit counter and PN state until a byte arrives. No filler bits are sent.
- End of frame, when payload bit BITS_PER_FRAME-33 handshakes:
  - frame_done pulses on the next cycle and frames_sent increments.
  - If hold_valid, go straight to SYNC with no gap cycle and pulse frame_start.
  - Otherwise go to IDLE.
- PN generator: h(x)=x^8+x^7+x^5+x^3+1, Fibonacci form, output = MSB, seed 0xFF at each payload start. The first four PN bytes are FF 48 0E C0.
- Bit counter width is $clog2(BITS_PER_FRAME). It resets to 0 at each SYNC entry and counts marker and payload bits together.

## Timing
- Reset values:
  - Outputs: valid_out=0, bit_out=0, ready_out=1, frame_start=0, frame_done=0, underrun=0, frames_sent=0.
  - Internal: state=IDLE, hold_valid=0.
- Latency: a byte accepted at edge N sets hold_valid after N. At edge N+1 the block enters SYNC with SYNC_WORD[31] on bit_out.
- With ready_in held high, a frame is exactly BITS_PER_FRAME consecutive valid cycles. Back-to-back frames are gapless if the upstream keeps hold_valid refilled.
- While valid_out && !ready_in, bit_out and valid_out hold stable, and all counters and PN state freeze.
- A byte may be accepted in the same cycle the shift register loads from hold_reg; the new byte lands in hold_reg.
- rst_in mid-frame discards the partial frame, the held byte, and the PN state; the block returns to IDLE next cycle.
- frames_sent wraps from 0xFFFF to 0.

## Structure
- Shared package lrpt_pkg holds:
  - CADU_SYNC_WORD = 32'h1ACFFC1D.
  - CADU_BITS_PER_FRAME = 8192.
  - PN_SEED = 8'hFF and the PN polynomial taps.
  - typedef enum cadu_framer_state {IDLE, SYNC, PAYLOAD}.
- One sub-module, ccsds_pn_gen, with ports clk, rst_in, init, adv and pn_bit. It is reused by the future derandomizer on the receive side.

## Test plan
- Reset, then one frame of 1020 bytes of 0x00 with RANDOMIZE=1 and ready_in=1 -> first 32 bits are 0x1ACFFC1D and the next 32 bits are 0xFF480EC0; frame_start and frame_done each pulse once; frames_sent=1.
- Same stimulus with RANDOMIZE=0 and incrementing bytes 0x00..0xFB (byte index mod 256) -> payload bits equal the input bytes MSB first.
- Random ready_in at 50% duty -> bit_out stays stable while stalled; the serialized stream is identical to the ready_in=1 run.
- Upstream withholds byte 10 for 20 cycles -> exactly one underrun pulse, valid_out low for the whole gap, no filler bits, and the PN sequence continues correctly.
- Three frames streamed continuously -> sync markers at bit offsets 0, 8192 and 16384 with no idle cycles; frames_sent=3.
- rst_in asserted at bit 500 of a frame -> all outputs return to their reset values next cycle; the next frame starts with a full sync marker.
